// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg: shared definitions for the clock time controller.
//   mode_t    : controller state, which is also the visible mode encoding
//   SEC_MOD   : seconds field modulus
//   MIN_MOD   : minutes field modulus
//   wrap_inc  : field value plus one, wrapped to 0 at or above the modulus
package clock_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_HR  = 2'd1,
      SET_MIN = 2'd2,
      SET_SEC = 2'd3
   } mode_t;

   localparam int unsigned SEC_MOD = 60;
   localparam int unsigned MIN_MOD = 60;

   // An out-of-range input (q >= modulus) also lands on 0, because q+1 is
   // then above the modulus as well.
   function automatic logic [6:0] wrap_inc(input logic [6:0] q, input int unsigned modulus);
      logic [7:0] sum;
      sum = {1'b0, q} + 8'd1;
      if ({24'd0, sum} >= modulus) begin
         return 7'd0;
      end
      return sum[6:0];
   endfunction

endpackage

// File: rtl/clock_time_ctrl_btn_edge.sv
// btn_edge: synchronous rising-edge detector for a debounced button level.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   btn   : debounced button level
//   rise  : high in the cycle where btn is 1 and was 0 the cycle before
// The history register resets to 1 so a button held through reset is not
// seen as a press when reset is released.
module btn_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic rise
);

   logic prev_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_reg <= 1'b1;
      end else begin
         prev_reg <= btn;
      end
   end

   assign rise = btn & ~prev_reg;

endmodule

// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: run/set controller for an external hh:mm:ss counter chain.
//   HR_MAX                     : hour field modulus
//   clk, rst_n                 : system clock, synchronous active-low reset
//   tick_1hz                   : one-cycle pulse per second
//   btn_mode, btn_inc          : debounced button levels
//   sec_q, min_q, hr_q         : current counter values
//   sec_rco, min_rco           : counter carries
//   sec_en, min_en, hr_en      : count enables (combinational, RUN only)
//   sec_load, min_load, hr_load: registered one-cycle preset strobes
//   load_data                  : registered preset value, holds between loads
//   mode                       : current state encoding
//   blink_mask                 : {hr,min,sec} blanking mask
// Optional feature: define CLOCK_CTRL_BLINK_EN to blink the selected field
// while setting; otherwise blink_mask is constant 000.
module clock_time_ctrl
   import clock_ctrl_pkg::*;
#(
   parameter int unsigned HR_MAX = 24
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_1hz,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [6:0] sec_q,
   input  logic [6:0] min_q,
   input  logic [6:0] hr_q,
   input  logic       sec_rco,
   input  logic       min_rco,
   output logic       sec_en,
   output logic       min_en,
   output logic       hr_en,
   output logic       sec_load,
   output logic       min_load,
   output logic       hr_load,
   output logic [6:0] load_data,
   output logic [1:0] mode,
   output logic [2:0] blink_mask
);

   mode_t      state_reg;
   logic       sec_load_reg, min_load_reg, hr_load_reg;
   logic [6:0] load_data_reg;

   // bit 0 = mode button, bit 1 = inc button
   logic [1:0] btn_bus;
   logic [1:0] rise_bus;
   logic       mode_rise, inc_rise;

   assign btn_bus = {btn_inc, btn_mode};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_edge
         btn_edge u_edge (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (btn_bus[gi]),
            .rise  (rise_bus[gi])
         );
      end
   endgenerate

   assign mode_rise = rise_bus[0];
   assign inc_rise  = rise_bus[1];

   // A mode press wins over a simultaneous inc press; the inc is dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= RUN;
         sec_load_reg  <= 1'b0;
         min_load_reg  <= 1'b0;
         hr_load_reg   <= 1'b0;
         load_data_reg <= 7'd0;
      end else begin
         sec_load_reg <= 1'b0;
         min_load_reg <= 1'b0;
         hr_load_reg  <= 1'b0;
         if (mode_rise) begin
            case (state_reg)
               RUN:     state_reg <= SET_HR;
               SET_HR:  state_reg <= SET_MIN;
               SET_MIN: state_reg <= SET_SEC;
               default: state_reg <= RUN;
            endcase
         end else if (inc_rise) begin
            case (state_reg)
               SET_HR: begin
                  hr_load_reg   <= 1'b1;
                  load_data_reg <= wrap_inc(hr_q, HR_MAX);
               end
               SET_MIN: begin
                  min_load_reg  <= 1'b1;
                  load_data_reg <= wrap_inc(min_q, MIN_MOD);
               end
               SET_SEC: begin
                  sec_load_reg  <= 1'b1;
                  load_data_reg <= wrap_inc(sec_q, SEC_MOD);
               end
               default: ;
            endcase
         end
      end
   end

   // Enables follow the current state, so a tick arriving in the same cycle
   // as the RUN->SET_HR press is still counted.
   always_comb begin
      sec_en = 1'b0;
      min_en = 1'b0;
      hr_en  = 1'b0;
      if (state_reg == RUN) begin
         sec_en = tick_1hz;
         min_en = sec_rco;
         hr_en  = min_rco;
      end
   end

   assign mode      = state_reg;
   assign sec_load  = sec_load_reg;
   assign min_load  = min_load_reg;
   assign hr_load   = hr_load_reg;
   assign load_data = load_data_reg;

`ifdef CLOCK_CTRL_BLINK_EN
   logic phase_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase_reg <= 1'b0;
      end else if (tick_1hz) begin
         phase_reg <= ~phase_reg;
      end
   end

   always_comb begin
      blink_mask = 3'b000;
      case (state_reg)
         SET_HR:  blink_mask[2] = phase_reg;
         SET_MIN: blink_mask[1] = phase_reg;
         SET_SEC: blink_mask[0] = phase_reg;
         default: ;
      endcase
   end
`else
   assign blink_mask = 3'b000;
`endif

endmodule
